// File: rtl/fifo_sync_level_pkg.sv
// Shared width helpers and operation encoding for the single-clock level-reporting FIFO.
// Imported by the FIFO top and its pointer sub-module.
package fifo_sync_level_pkg;

    // Encoding of {wr_acc, rd_acc} for the level update decode.
    typedef enum logic [1:0] {
        OpIdle = 2'b00,
        OpRd   = 2'b01,
        OpWr   = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    // Width that holds 0..depth inclusive.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; at least one bit so depth 1 still has a legal vector.
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned depth,
                                     input int unsigned afull, input int unsigned aempty);
        return (width >= 1) && (depth >= 1) && (afull <= depth) && (aempty <= depth);
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-p_DEPTH pointer: advances on inc, wraps from p_DEPTH-1 to 0.
// Synchronous active-high reset returns it to 0.
module fifo_ptr_wrap #(
    parameter int unsigned p_DEPTH = 16,
    parameter int unsigned p_PTR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [p_PTR_W-1:0] ptr
);

    logic [p_PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == p_PTR_W'(p_DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + p_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_level.sv
// Single-clock FIFO of any depth with fill level, programmable almost flags, sticky
// overflow/underflow and a choice of first-word-fall-through or registered read.
module fifo_sync_level
    import fifo_sync_level_pkg::*;
#(
    parameter int unsigned p_WIDTH  = 8,
    parameter int unsigned p_DEPTH  = 16,
    parameter int unsigned p_AFULL  = 14,
    parameter int unsigned p_AEMPTY = 2,
    parameter int unsigned p_FWFT   = 1,
    localparam int unsigned lp_LVL_W = lvl_width(p_DEPTH),
    localparam int unsigned lp_PTR_W = ptr_width(p_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [p_WIDTH-1:0]  wrdata,
    input  logic                wrena,
    input  logic                rdena,
    output logic [p_WIDTH-1:0]  rddata,
    output logic                rdvalid,
    output logic                full,
    output logic                empty,
    output logic                afull,
    output logic                aempty,
    output logic [lp_LVL_W-1:0] level,
    output logic                overflow,
    output logic                underflow
);

    if (!params_ok(p_WIDTH, p_DEPTH, p_AFULL, p_AEMPTY)) begin : g_bad_params
        $error("fifo_sync_level: illegal parameters (width/depth < 1 or threshold > depth)");
    end

    logic [p_WIDTH-1:0]  mem_q [p_DEPTH];
    logic [lp_PTR_W-1:0] wr_ptr, rd_ptr;
    logic [lp_LVL_W-1:0] level_q, level_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_acc, rd_acc, mem_we;

    // Accepts use this cycle's registered flags: no write-through, no full-bypass.
    always_comb begin
        wr_acc = wrena & ~full;
        rd_acc = rdena & ~empty;
        mem_we = wr_acc & ~rst;
    end

    always_comb begin
        full   = (level_q == lp_LVL_W'(p_DEPTH));
        empty  = (level_q == '0);
        afull  = (32'(level_q) >= p_AFULL);
        aempty = (32'(level_q) <= p_AEMPTY);
    end

    always_comb begin
        level_d = level_q;
        unique case (fifo_op_e'({wr_acc, rd_acc}))
            OpWr:    level_d = level_q + lp_LVL_W'(1);
            OpRd:    level_d = level_q - lp_LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        overflow_d  = overflow_q | (wrena & full);
        underflow_d = underflow_q | (rdena & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; occupancy tracking makes stale words invisible.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr] <= wrdata;
        end
    end

    fifo_ptr_wrap #(
        .p_DEPTH (p_DEPTH),
        .p_PTR_W (lp_PTR_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr_wrap #(
        .p_DEPTH (p_DEPTH),
        .p_PTR_W (lp_PTR_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    if (p_FWFT != 0) begin : g_fwft
        always_comb begin
            rddata  = mem_q[rd_ptr];
            rdvalid = ~empty;
        end
    end else begin : g_reg
        logic [p_WIDTH-1:0] rddata_q, rddata_d;
        logic               rdvalid_q, rdvalid_d;

        // Data register holds its last value when no read is accepted.
        always_comb begin
            rddata_d  = rddata_q;
            rdvalid_d = rd_acc;
            if (rd_acc) begin
                rddata_d = mem_q[rd_ptr];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rddata_q  <= '0;
                rdvalid_q <= 1'b0;
            end else begin
                rddata_q  <= rddata_d;
                rdvalid_q <= rdvalid_d;
            end
        end

        always_comb begin
            rddata  = rddata_q;
            rdvalid = rdvalid_q;
        end
    end

    always_comb begin
        level     = level_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_fifo_sync_level.sv
// Directed bench for fifo_sync_level: a depth-5 FWFT instance driven from a vector table
// and hand sequences, plus a depth-5 registered-read instance.
module tb_fifo_sync_level;

    localparam int unsigned W = 8;
    localparam int unsigned D = 5;
    localparam int unsigned LW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // FWFT instance
    logic [W-1:0]  f_wd = '0;
    logic          f_wr = 1'b0, f_rd = 1'b0;
    logic [W-1:0]  f_rdata;
    logic          f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [LW-1:0] f_level;

    // Registered-read instance
    logic [W-1:0]  r_wd = '0;
    logic          r_wr = 1'b0, r_rd = 1'b0;
    logic [W-1:0]  r_rdata;
    logic          r_rvalid, r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;
    logic [LW-1:0] r_level;

    fifo_sync_level #(
        .p_WIDTH (W), .p_DEPTH (D), .p_AFULL (4), .p_AEMPTY (1), .p_FWFT (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .wrdata (f_wd), .wrena (f_wr), .rdena (f_rd),
        .rddata (f_rdata), .rdvalid (f_rvalid), .full (f_full), .empty (f_empty),
        .afull (f_afull), .aempty (f_aempty), .level (f_level), .overflow (f_ovf),
        .underflow (f_udf)
    );

    fifo_sync_level #(
        .p_WIDTH (W), .p_DEPTH (D), .p_AFULL (4), .p_AEMPTY (1), .p_FWFT (0)
    ) u_reg (
        .clk (clk), .rst (rst), .wrdata (r_wd), .wrena (r_wr), .rdena (r_rd),
        .rddata (r_rdata), .rdvalid (r_rvalid), .full (r_full), .empty (r_empty),
        .afull (r_afull), .aempty (r_aempty), .level (r_level), .overflow (r_ovf),
        .underflow (r_udf)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] wd;
        int         lvl;
        logic       full;
        logic       empty;
        logic       afull;
        logic       aempty;
        logic       ovf;
        logic       udf;
        logic       dchk;
        logic [7:0] head;
    } vec_t;

    vec_t vt [13];
    logic [7:0] q [$];
    logic [7:0] exp_head;

    initial begin
        // wr rd wd lvl full empty afull aempty ovf udf dchk head
        vt[0]  = '{1, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 1, 8'h11};
        vt[1]  = '{1, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0, 1, 8'h11};
        vt[2]  = '{1, 0, 8'h33, 3, 0, 0, 0, 0, 0, 0, 1, 8'h11};
        vt[3]  = '{1, 0, 8'h44, 4, 0, 0, 1, 0, 0, 0, 1, 8'h11};
        vt[4]  = '{1, 0, 8'h55, 5, 1, 0, 1, 0, 0, 0, 1, 8'h11};
        // full: read pops 0x11, write of 0x66 dropped
        vt[5]  = '{1, 1, 8'h66, 4, 0, 0, 1, 0, 1, 0, 1, 8'h22};
        vt[6]  = '{0, 1, 8'h00, 3, 0, 0, 0, 0, 1, 0, 1, 8'h33};
        vt[7]  = '{0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 0, 1, 8'h44};
        vt[8]  = '{0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 0, 1, 8'h55};
        vt[9]  = '{0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 0, 0, 8'h00};
        // empty: read rejected, write of 0x99 lands
        vt[10] = '{1, 1, 8'h99, 1, 0, 0, 0, 1, 1, 1, 1, 8'h99};
        vt[11] = '{0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 1, 0, 8'h00};
        vt[12] = '{0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 1, 0, 8'h00};

        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_level", int'(f_level), 0);
        chk("rst_empty", int'(f_empty), 1);
        chk("rst_full", int'(f_full), 0);
        chk("rst_aempty", int'(f_aempty), 1);
        chk("rst_afull", int'(f_afull), 0);
        chk("rst_rdvalid", int'(f_rvalid), 0);
        chk("rst_ovf", int'(f_ovf), 0);
        chk("rst_udf", int'(f_udf), 0);
        chk("rst_reg_rddata", int'(r_rdata), 0);
        chk("rst_reg_rdvalid", int'(r_rvalid), 0);

        // Fill, full collision, drain, empty collision
        for (int i = 0; i < 13; i++) begin
            f_wr = vt[i].wr;
            f_rd = vt[i].rd;
            f_wd = vt[i].wd;
            step();
            chk($sformatf("vec%0d_level", i), int'(f_level), vt[i].lvl);
            chk($sformatf("vec%0d_full", i), int'(f_full), int'(vt[i].full));
            chk($sformatf("vec%0d_empty", i), int'(f_empty), int'(vt[i].empty));
            chk($sformatf("vec%0d_afull", i), int'(f_afull), int'(vt[i].afull));
            chk($sformatf("vec%0d_aempty", i), int'(f_aempty), int'(vt[i].aempty));
            chk($sformatf("vec%0d_ovf", i), int'(f_ovf), int'(vt[i].ovf));
            chk($sformatf("vec%0d_udf", i), int'(f_udf), int'(vt[i].udf));
            chk($sformatf("vec%0d_rdvalid", i), int'(f_rvalid), int'(!vt[i].empty));
            if (vt[i].dchk) begin
                chk($sformatf("vec%0d_rddata", i), int'(f_rdata), int'(vt[i].head));
            end
        end
        f_wr = 1'b0;
        f_rd = 1'b0;

        // Wrap: keep 3 words resident, 13 simultaneous push/pop pairs cross the end twice+
        for (int i = 0; i < 3; i++) begin
            f_wr = 1'b1;
            f_wd = 8'h64 + 8'(i);
            q.push_back(f_wd);
            step();
        end
        for (int i = 0; i < 13; i++) begin
            f_wr = 1'b1;
            f_rd = 1'b1;
            f_wd = 8'(i);
            exp_head = q.pop_front();
            chk($sformatf("wrap%0d_head", i), int'(f_rdata), int'(exp_head));
            q.push_back(f_wd);
            step();
            chk($sformatf("wrap%0d_level", i), int'(f_level), 3);
        end
        f_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f_rd = 1'b1;
            exp_head = q.pop_front();
            chk($sformatf("wrap_drain%0d", i), int'(f_rdata), int'(exp_head));
            step();
        end
        f_rd = 1'b0;
        chk("wrap_empty", int'(f_empty), 1);

        // Registered read: data one cycle after the accepted rdena, then held
        r_wr = 1'b1;
        r_wd = 8'hA5;
        step();
        r_wr = 1'b0;
        chk("reg_wr_rdvalid", int'(r_rvalid), 0);
        chk("reg_wr_level", int'(r_level), 1);
        r_rd = 1'b1;
        step();
        r_rd = 1'b0;
        chk("reg_rd_rdvalid", int'(r_rvalid), 1);
        chk("reg_rd_rddata", int'(r_rdata), 8'hA5);
        chk("reg_rd_empty", int'(r_empty), 1);
        step();
        chk("reg_idle_rdvalid", int'(r_rvalid), 0);
        chk("reg_idle_rddata", int'(r_rdata), 8'hA5);
        r_rd = 1'b1;
        step();
        r_rd = 1'b0;
        chk("reg_under_rdvalid", int'(r_rvalid), 0);
        chk("reg_under_udf", int'(r_udf), 1);

        // Reset mid-stream: 3 words resident with overflow set
        for (int i = 0; i < 6; i++) begin
            f_wr = 1'b1;
            f_wd = 8'hC0 + 8'(i);
            step();
        end
        f_wr = 1'b0;
        f_rd = 1'b1;
        step();
        step();
        f_rd = 1'b0;
        chk("pre_rst_level", int'(f_level), 3);
        chk("pre_rst_ovf", int'(f_ovf), 1);
        rst = 1'b1;
        f_wr = 1'b1;
        f_wd = 8'hEE;
        step();
        rst = 1'b0;
        f_wr = 1'b0;
        chk("mid_rst_level", int'(f_level), 0);
        chk("mid_rst_empty", int'(f_empty), 1);
        chk("mid_rst_ovf", int'(f_ovf), 0);
        chk("mid_rst_udf", int'(f_udf), 0);
        chk("mid_rst_rdvalid", int'(f_rvalid), 0);
        chk("mid_rst_reg_udf", int'(r_udf), 0);
        chk("mid_rst_reg_rddata", int'(r_rdata), 0);
        f_wr = 1'b1;
        f_wd = 8'h7E;
        step();
        f_wr = 1'b0;
        chk("post_rst_level", int'(f_level), 1);
        chk("post_rst_rddata", int'(f_rdata), 8'h7E);
        chk("post_rst_rdvalid", int'(f_rvalid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
